dac_play_ctrl: RTL
==================

DAC_PLAY_CTRL -- requirements
Module: dac_play_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of sample-period configuration.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, log2 of playback FIFO depth.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 cfg_enable  in  1  playback enable, level-sensitive.
REQ-006 cfg_period  in  DATA_WIDTH  clocks per stereo frame.
REQ-007 cfg_start_level  in  ADDR_WIDTH+1  FIFO words required before playback (re)starts.
REQ-008 cfg_low_level  in  ADDR_WIDTH+1  low-water threshold.
REQ-009 clear_underrun  in  1  one-cycle pulse, clears sticky underrun.
REQ-010 fifo_count  in  ADDR_WIDTH+1  current FIFO occupancy in words.
REQ-011 fifo_rd  out  1  FIFO pop strobe, one word per asserted cycle.
REQ-012 channel_sel  out  1  0 = left word popped, 1 = right word popped.
REQ-013 frame_strobe  out  1  one-cycle pulse when a complete L/R pair has been popped.
REQ-014 mute  out  1  DAC output forced to mid-scale.
REQ-015 underrun  out  1  sticky underrun flag.
REQ-016 underrun_count  out  8  saturating underrun event counter.
REQ-017 low_water  out  1  occupancy below cfg_low_level while active.
REQ-018 busy  out  1  high in every state except S_IDLE.

Function
REQ-019 States SHALL be S_IDLE, S_PREFILL, S_WAIT_TICK, S_POP_L, S_POP_R, S_UNDERRUN.
REQ-020 S_IDLE -> S_PREFILL when cfg_enable=1; otherwise remain.
REQ-021 S_PREFILL -> S_WAIT_TICK when fifo_count >= max(cfg_start_level,2); period counter cleared on entry to S_WAIT_TICK.
REQ-022 Period counter SHALL count every cycle in S_WAIT_TICK, S_POP_L and S_POP_R; tick when count == P-1, where P = max(cfg_period,4); counter wraps to 0 on tick.
REQ-023 On tick in S_WAIT_TICK: fifo_count >= 2 -> S_POP_L; else -> S_UNDERRUN.
REQ-024 S_POP_L: fifo_rd=1, channel_sel=0, unconditionally -> S_POP_R next cycle.
REQ-025 S_POP_R: fifo_rd=1, channel_sel=1, frame_strobe=1; -> S_WAIT_TICK, or -> S_IDLE if cfg_enable=0.
REQ-026 Consecutive S_POP_L entries SHALL be exactly P clocks apart while the FIFO does not underrun.
REQ-027 S_UNDERRUN: one cycle; set underrun; underrun_count += 1, saturating at 255; -> S_PREFILL (or S_IDLE if cfg_enable=0).
REQ-028 mute SHALL be 1 in S_IDLE, S_PREFILL and S_UNDERRUN, 0 otherwise; registered, updating on the state transition.
REQ-029 cfg_enable=0 SHALL force -> S_IDLE next cycle from S_PREFILL or S_WAIT_TICK; in S_POP_L the pair completes via S_POP_R first (L/R alignment preserved).
REQ-030 clear_underrun clears underrun; if it coincides with a new underrun event, set wins.
REQ-031 underrun_count SHALL clear only on reset.
REQ-032 low_water = busy & (fifo_count < cfg_low_level), registered, one-cycle latency.
REQ-033 cfg_period and cfg_start_level changes SHALL take effect at the next counter wrap or state entry; no glitch is required mid-period.

Reset
REQ-034 resetn low SHALL asynchronously force state S_IDLE, period counter 0, fifo_rd 0, channel_sel 0, frame_strobe 0, mute 1, underrun 0, underrun_count 0, low_water 0, busy 0.
REQ-035 Reset asserted mid-pair (S_POP_L) SHALL abort the pair; no further fifo_rd until re-enabled.

Structure
REQ-036 Shared package dac_pkg SHALL hold state encodings (3 bits) and MIN_PERIOD=4.
REQ-037 Period counter SHALL be sub-module dac_period_timer (clear, run, period in; tick out).

Verification
REQ-038 P=10, start_level=4, FIFO preloaded with 8 words, enable -> fifo_rd pairs (ch 0 then 1) with L pops 10 clocks apart; 4 frame_strobes; then underrun=1, underrun_count=1, mute=1.
REQ-039 cfg_period=1 -> pop pairs spaced 4 clocks (clamped).
REQ-040 Deassert enable during S_POP_L -> S_POP_R still issued (2 pops total), then S_IDLE, mute=1.
REQ-041 Force 300 underruns -> underrun_count holds at 255; clear_underrun coincident with underrun -> underrun stays 1.
REQ-042 fifo_count=3, low_level=5, enabled -> low_water=1 one cycle later; disable -> 0.
REQ-043 resetn low during S_POP_L -> all outputs at reset values immediately, no further fifo_rd.

Source files
------------

// File: rtl/dac_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dac_pkg : shared state encodings and limits for DAC playback     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package dac_pkg;

  localparam int MIN_PERIOD = 4;
  localparam int MIN_START  = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREFILL   = 3'd1,
    S_WAIT_TICK = 3'd2,
    S_POP_L     = 3'd3,
    S_POP_R     = 3'd4,
    S_UNDERRUN  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dac_period_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dac_period_timer : frame-period counter, ticks every P clocks    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module dac_period_timer
  import dac_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] period,
  output logic                  tick
);

  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] period_q;
  logic [DATA_WIDTH-1:0] period_eff;

  assign period_eff = (period < DATA_WIDTH'(MIN_PERIOD)) ? DATA_WIDTH'(MIN_PERIOD) : period;
  assign tick       = run && (count == period_q - 1'b1);

  // The period is sampled only on clear or wrap so a mid-frame change cannot shorten a frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      period_q <= DATA_WIDTH'(MIN_PERIOD);
    end else if (clear) begin
      count    <= '0;
      period_q <= period_eff;
    end else if (run) begin
      if (tick) begin
        count    <= '0;
        period_q <= period_eff;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_play_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dac_play_ctrl : paced stereo FIFO playback with underrun handling|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module dac_play_ctrl
  import dac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_enable,
  input  logic [DATA_WIDTH-1:0] cfg_period,
  input  logic [ADDR_WIDTH:0]   cfg_start_level,
  input  logic [ADDR_WIDTH:0]   cfg_low_level,
  input  logic                  clear_underrun,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_rd,
  output logic                  channel_sel,
  output logic                  frame_strobe,
  output logic                  mute,
  output logic                  underrun,
  output logic [7:0]            underrun_count,
  output logic                  low_water,
  output logic                  busy
);

  state_t            state;
  state_t            next_state;
  logic              tick;
  logic              timer_clear;
  logic              timer_run;
  logic              underrun_evt;
  logic [ADDR_WIDTH:0] start_thr;

  assign start_thr    = (cfg_start_level < (ADDR_WIDTH+1)'(MIN_START)) ?
                        (ADDR_WIDTH+1)'(MIN_START) : cfg_start_level;
  assign timer_run    = (state == S_WAIT_TICK) || (state == S_POP_L) || (state == S_POP_R);
  assign timer_clear  = (state == S_PREFILL) && (next_state == S_WAIT_TICK);
  assign underrun_evt = (next_state == S_UNDERRUN);

  dac_period_timer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (timer_clear),
    .run    (timer_run),
    .period (cfg_period),
    .tick   (tick)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (cfg_enable) next_state = S_PREFILL;
      S_PREFILL: begin
        if (!cfg_enable)                  next_state = S_IDLE;
        else if (fifo_count >= start_thr) next_state = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!cfg_enable) next_state = S_IDLE;
        else if (tick)   next_state = (fifo_count >= (ADDR_WIDTH+1)'(MIN_START)) ?
                                      S_POP_L : S_UNDERRUN;
      end
      // A started pair always finishes so left/right alignment survives a disable.
      S_POP_L:     next_state = S_POP_R;
      S_POP_R:     next_state = cfg_enable ? S_WAIT_TICK : S_IDLE;
      S_UNDERRUN:  next_state = cfg_enable ? S_PREFILL : S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they change together with the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      fifo_rd        <= 1'b0;
      channel_sel    <= 1'b0;
      frame_strobe   <= 1'b0;
      mute           <= 1'b1;
      busy           <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= 8'd0;
      low_water      <= 1'b0;
    end else begin
      state        <= next_state;
      fifo_rd      <= (next_state == S_POP_L) || (next_state == S_POP_R);
      channel_sel  <= (next_state == S_POP_R);
      frame_strobe <= (next_state == S_POP_R);
      mute         <= (next_state == S_IDLE) || (next_state == S_PREFILL) ||
                      (next_state == S_UNDERRUN);
      busy         <= (next_state != S_IDLE);
      if (underrun_evt)        underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
      if (underrun_evt && (underrun_count != 8'hFF))
        underrun_count <= underrun_count + 8'd1;
      low_water    <= busy && (fifo_count < cfg_low_level);
    end
  end

endmodule
`default_nettype wire
